// File: rtl/sd_spi_card_responder.sv
// SD-card SPI-mode card end: command frames in, R1/R3/R7 out,
// single-block read (CMD17) and write (CMD24) through a sector buffer.
module sd_spi_card_responder #(
  parameter int          NCR_BYTES         = 1,
  parameter int          READ_GAP          = 2,
  parameter int          ACMD41_BUSY_POLLS = 2,
  parameter int          BUSY_BYTES        = 4,
  parameter logic [31:0] OCR_VALUE         = 32'hC0FF8000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  output logic        card_idle,
  output logic [31:0] sector_addr,
  output logic        blk_rd_start,
  output logic        blk_wr_done,
  output logic [8:0]  buf_addr,
  input  logic [7:0]  buf_rd_data,
  output logic        buf_wr_en,
  output logic [7:0]  buf_wr_data
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CMD      = 4'd1;
  localparam logic [3:0] S_NCR      = 4'd2;
  localparam logic [3:0] S_RESP     = 4'd3;
  localparam logic [3:0] S_RD_GAP   = 4'd4;
  localparam logic [3:0] S_RD_TOK   = 4'd5;
  localparam logic [3:0] S_RD_DATA  = 4'd6;
  localparam logic [3:0] S_RD_CRC   = 4'd7;
  localparam logic [3:0] S_WR_TOKEN = 4'd8;
  localparam logic [3:0] S_WR_DATA  = 4'd9;
  localparam logic [3:0] S_WR_CRC   = 4'd10;
  localparam logic [3:0] S_WR_RESP  = 4'd11;
  localparam logic [3:0] S_WR_BUSY  = 4'd12;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_READ  = 2'd1;
  localparam logic [1:0] P_WRITE = 2'd2;

  localparam logic [8:0] C_NCR   = 9'(NCR_BYTES - 1);
  localparam logic [8:0] C_GAP   = 9'(READ_GAP - 1);
  localparam logic [8:0] C_BUSY  = 9'(BUSY_BYTES - 1);
  localparam logic [7:0] C_POLLS = 8'(ACMD41_BUSY_POLLS);

  logic [3:0]  r_state;
  logic [8:0]  r_cnt;
  logic [5:0]  r_cmd;
  logic [31:0] r_arg;
  logic [39:0] r_resp;
  logic [2:0]  r_rlen;
  logic [1:0]  r_post;
  logic        r_app;
  logic [7:0]  r_polls;
  logic [8:0]  r_widx;

  logic        w_idle_nx;
  logic        w_app_nx;
  logic [7:0]  w_polls_nx;
  logic [7:0]  w_flags;
  logic [7:0]  w_r1;
  logic [2:0]  w_len;
  logic [31:0] w_tail;
  logic [1:0]  w_post;
  logic        w_accept;

  always_comb begin
    w_idle_nx  = card_idle;
    w_app_nx   = 1'b0;
    w_polls_nx = r_polls;
    w_flags    = 8'h00;
    w_len      = 3'd0;
    w_tail     = 32'h0;
    w_post     = P_IDLE;
    w_accept   = 1'b0;
    unique case (r_cmd)
      6'd0: begin
        w_idle_nx  = 1'b1;
        w_polls_nx = 8'h00;
      end
      6'd8: begin
        w_len  = 3'd4;
        w_tail = r_arg;
      end
      6'd55: w_app_nx = 1'b1;
      6'd41: begin
        if (!r_app)
          w_flags = 8'h04;
        else if (r_polls < C_POLLS)
          w_polls_nx = r_polls + 8'd1;
        else
          w_idle_nx = 1'b0;
      end
      6'd58: begin
        w_len  = 3'd4;
        w_tail = OCR_VALUE;
      end
      6'd17, 6'd24: begin
        if (card_idle) begin
          w_flags = 8'h04;
        end else begin
          w_accept = 1'b1;
          w_post   = (r_cmd == 6'd17) ? P_READ : P_WRITE;
        end
      end
      default: w_flags = 8'h04;
    endcase
    w_r1 = {7'b0, w_idle_nx} | w_flags;
  end

  // buf_rd_data for buf_addr is ready one cycle after the address moves,
  // well before the next byte exchange completes.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 9'd0;
      r_cmd        <= 6'd0;
      r_arg        <= 32'h0;
      r_resp       <= 40'h0;
      r_rlen       <= 3'd0;
      r_post       <= P_IDLE;
      r_app        <= 1'b0;
      r_polls      <= 8'h00;
      r_widx       <= 9'd0;
      tx_data      <= 8'hFF;
      card_idle    <= 1'b1;
      sector_addr  <= 32'h0;
      blk_rd_start <= 1'b0;
      blk_wr_done  <= 1'b0;
      buf_addr     <= 9'd0;
      buf_wr_en    <= 1'b0;
      buf_wr_data  <= 8'h00;
    end else begin
      blk_rd_start <= 1'b0;
      blk_wr_done  <= 1'b0;
      buf_wr_en    <= 1'b0;
      if (cs_n) begin
        r_state <= S_IDLE;
        r_cnt   <= 9'd0;
        tx_data <= 8'hFF;
      end else if (rx_valid) begin
        unique case (r_state)
          S_IDLE: begin
            tx_data <= 8'hFF;
            if (rx_data[7:6] == 2'b01) begin
              r_cmd   <= rx_data[5:0];
              r_cnt   <= 9'd0;
              r_state <= S_CMD;
            end
          end
          S_CMD: begin
            tx_data <= 8'hFF;
            if (r_cnt == 9'd4) begin
              card_idle <= w_idle_nx;
              r_app     <= w_app_nx;
              r_polls   <= w_polls_nx;
              r_resp    <= {w_r1, w_tail};
              r_rlen    <= w_len;
              r_post    <= w_post;
              if (w_accept) begin
                sector_addr  <= r_arg;
                blk_rd_start <= (w_post == P_READ);
                buf_addr     <= 9'd0;
              end
              r_cnt   <= C_NCR;
              r_state <= S_NCR;
            end else begin
              r_arg <= {r_arg[23:0], rx_data};
              r_cnt <= r_cnt + 9'd1;
            end
          end
          S_NCR: begin
            if (r_cnt == 9'd0) begin
              tx_data <= r_resp[39:32];
              r_resp  <= {r_resp[31:0], 8'h00};
              r_cnt   <= {6'b0, r_rlen};
              r_state <= S_RESP;
            end else begin
              tx_data <= 8'hFF;
              r_cnt   <= r_cnt - 9'd1;
            end
          end
          S_RESP: begin
            if (r_cnt != 9'd0) begin
              tx_data <= r_resp[39:32];
              r_resp  <= {r_resp[31:0], 8'h00};
              r_cnt   <= r_cnt - 9'd1;
            end else begin
              unique case (r_post)
                P_READ: begin
                  if (READ_GAP == 0) begin
                    tx_data <= 8'hFE;
                    r_state <= S_RD_TOK;
                  end else begin
                    tx_data <= 8'hFF;
                    r_cnt   <= C_GAP;
                    r_state <= S_RD_GAP;
                  end
                end
                P_WRITE: begin
                  tx_data <= 8'hFF;
                  r_state <= S_WR_TOKEN;
                end
                default: begin
                  tx_data <= 8'hFF;
                  r_state <= S_IDLE;
                end
              endcase
            end
          end
          S_RD_GAP: begin
            if (r_cnt == 9'd0) begin
              tx_data <= 8'hFE;
              r_state <= S_RD_TOK;
            end else begin
              tx_data <= 8'hFF;
              r_cnt   <= r_cnt - 9'd1;
            end
          end
          S_RD_TOK: begin
            tx_data  <= buf_rd_data;
            buf_addr <= buf_addr + 9'd1;
            r_cnt    <= 9'd511;
            r_state  <= S_RD_DATA;
          end
          S_RD_DATA: begin
            if (r_cnt == 9'd0) begin
              tx_data <= 8'hFF;
              r_cnt   <= 9'd1;
              r_state <= S_RD_CRC;
            end else begin
              tx_data  <= buf_rd_data;
              buf_addr <= buf_addr + 9'd1;
              r_cnt    <= r_cnt - 9'd1;
            end
          end
          S_RD_CRC: begin
            tx_data <= 8'hFF;
            if (r_cnt == 9'd0)
              r_state <= S_IDLE;
            else
              r_cnt <= r_cnt - 9'd1;
          end
          S_WR_TOKEN: begin
            tx_data <= 8'hFF;
            if (rx_data == 8'hFE) begin
              r_widx  <= 9'd0;
              r_state <= S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            tx_data     <= 8'hFF;
            buf_wr_en   <= 1'b1;
            buf_addr    <= r_widx;
            buf_wr_data <= rx_data;
            r_widx      <= r_widx + 9'd1;
            if (r_widx == 9'd511) begin
              r_cnt   <= 9'd1;
              r_state <= S_WR_CRC;
            end
          end
          S_WR_CRC: begin
            if (r_cnt == 9'd0) begin
              tx_data <= 8'h05;
              r_state <= S_WR_RESP;
            end else begin
              tx_data <= 8'hFF;
              r_cnt   <= r_cnt - 9'd1;
            end
          end
          S_WR_RESP: begin
            tx_data <= 8'h00;
            r_cnt   <= C_BUSY;
            r_state <= S_WR_BUSY;
          end
          S_WR_BUSY: begin
            if (r_cnt == 9'd0) begin
              tx_data     <= 8'hFF;
              blk_wr_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              tx_data <= 8'h00;
              r_cnt   <= r_cnt - 9'd1;
            end
          end
          default: begin
            tx_data <= 8'hFF;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder: byte exchanges with a
// registered-read sector buffer model and hand-computed responses.
module tb_sd_spi_card_responder;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  tx_data;
  logic        card_idle;
  logic [31:0] sector_addr;
  logic        blk_rd_start;
  logic        blk_wr_done;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_rd_data;
  logic        buf_wr_en;
  logic [7:0]  buf_wr_data;

  always #5 sys_clk = ~sys_clk;

  sd_spi_card_responder dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .cs_n         (cs_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .card_idle    (card_idle),
    .sector_addr  (sector_addr),
    .blk_rd_start (blk_rd_start),
    .blk_wr_done  (blk_wr_done),
    .buf_addr     (buf_addr),
    .buf_rd_data  (buf_rd_data),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_data  (buf_wr_data)
  );

  logic [7:0] mem [512];
  int n_vec = 0;
  int n_err = 0;
  int wr_n = 0;
  int wr_bad = 0;
  int n_rd_start = 0;
  int n_wr_done = 0;

  // buffer preloads with addr[7:0] during reset
  always @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i);
      buf_rd_data <= 8'h00;
    end else begin
      buf_rd_data <= mem[buf_addr];
      if (buf_wr_en) begin
        mem[buf_addr] <= buf_wr_data;
        if (buf_addr !== 9'(wr_n)) wr_bad++;
        wr_n++;
      end
      if (blk_rd_start) n_rd_start++;
      if (blk_wr_done) n_wr_done++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
    @(negedge sys_clk);
    miso     = tx_data;
    rx_data  = mosi;
    rx_valid = 1'b1;
    @(negedge sys_clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] crc);
    logic [7:0] b;
    xfer({2'b01, idx}, b);
    xfer(arg[31:24], b);
    xfer(arg[23:16], b);
    xfer(arg[15:8], b);
    xfer(arg[7:0], b);
    xfer(crc, b);
  endtask

  logic [7:0] b;
  logic [7:0] d0, d255, d511;
  int rd_bad;

  initial begin
    repeat (4) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_tx", tx_data, 32'hFF);
    chk("rst_idle", card_idle, 1);
    chk("rst_sector", sector_addr, 0);
    chk("rst_bufaddr", buf_addr, 0);
    chk("rst_pulses", {blk_rd_start, blk_wr_done, buf_wr_en}, 0);
    chk("rst_wdata", buf_wr_data, 0);

    for (int i = 0; i < 10; i++) xfer(8'hFF, b);
    cs_n = 1'b0;
    @(negedge sys_clk);

    send_cmd(6'd0, 32'h0, 8'h95);
    xfer(8'hFF, b); chk("cmd0_ncr", b, 32'hFF);
    xfer(8'hFF, b); chk("cmd0_r1", b, 32'h01);
    xfer(8'hFF, b); chk("cmd0_after", b, 32'hFF);
    chk("cmd0_idle", card_idle, 1);

    send_cmd(6'd8, 32'h000001AA, 8'h87);
    xfer(8'hFF, b); chk("cmd8_ncr", b, 32'hFF);
    xfer(8'hFF, b); chk("cmd8_r1", b, 32'h01);
    xfer(8'hFF, b); chk("cmd8_b1", b, 32'h00);
    xfer(8'hFF, b); chk("cmd8_b2", b, 32'h00);
    xfer(8'hFF, b); chk("cmd8_b3", b, 32'h01);
    xfer(8'hFF, b); chk("cmd8_b4", b, 32'hAA);
    xfer(8'hFF, b); chk("cmd8_after", b, 32'hFF);

    send_cmd(6'd17, 32'h99, 8'hFF);
    xfer(8'hFF, b); chk("ill17_ncr", b, 32'hFF);
    xfer(8'hFF, b); chk("ill17_r1", b, 32'h05);
    xfer(8'hFF, b); chk("ill17_after", b, 32'hFF);
    chk("ill17_sector", sector_addr, 0);
    chk("ill17_nostart", n_rd_start, 0);

    for (int k = 0; k < 3; k++) begin
      send_cmd(6'd55, 32'h0, 8'hFF);
      xfer(8'hFF, b); chk("cmd55_ncr", b, 32'hFF);
      xfer(8'hFF, b); chk("cmd55_r1", b, 32'h01);
      send_cmd(6'd41, 32'h40000000, 8'hFF);
      xfer(8'hFF, b); chk("acmd41_ncr", b, 32'hFF);
      xfer(8'hFF, b);
      chk("acmd41_r1", b, (k < 2) ? 32'h01 : 32'h00);
    end
    chk("init_idle", card_idle, 0);

    send_cmd(6'd58, 32'h0, 8'hFF);
    xfer(8'hFF, b); chk("cmd58_ncr", b, 32'hFF);
    xfer(8'hFF, b); chk("cmd58_r1", b, 32'h00);
    xfer(8'hFF, b); chk("cmd58_o1", b, 32'hC0);
    xfer(8'hFF, b); chk("cmd58_o2", b, 32'hFF);
    xfer(8'hFF, b); chk("cmd58_o3", b, 32'h80);
    xfer(8'hFF, b); chk("cmd58_o4", b, 32'h00);

    send_cmd(6'd13, 32'h0, 8'hFF);
    xfer(8'hFF, b);
    xfer(8'hFF, b); chk("unk_r1", b, 32'h04);
    send_cmd(6'd41, 32'h0, 8'hFF);
    xfer(8'hFF, b);
    xfer(8'hFF, b); chk("cmd41_noapp", b, 32'h04);

    send_cmd(6'd17, 32'h00001234, 8'hFF);
    xfer(8'hFF, b); chk("rd_ncr", b, 32'hFF);
    xfer(8'hFF, b); chk("rd_r1", b, 32'h00);
    xfer(8'hFF, b); chk("rd_gap1", b, 32'hFF);
    xfer(8'hFF, b); chk("rd_gap2", b, 32'hFF);
    xfer(8'hFF, b); chk("rd_token", b, 32'hFE);
    rd_bad = 0;
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, b);
      if (b !== 8'(i)) rd_bad++;
      if (i == 0) d0 = b;
      if (i == 255) d255 = b;
      if (i == 511) d511 = b;
    end
    chk("rd_bad_bytes", rd_bad, 0);
    chk("rd_d0", d0, 32'h00);
    chk("rd_d255", d255, 32'hFF);
    chk("rd_d511", d511, 32'hFF);
    xfer(8'hFF, b); chk("rd_crc1", b, 32'hFF);
    xfer(8'hFF, b); chk("rd_crc2", b, 32'hFF);
    chk("rd_start_cnt", n_rd_start, 1);
    chk("rd_sector", sector_addr, 32'h00001234);

    send_cmd(6'd24, 32'h00000055, 8'hFF);
    xfer(8'hFF, b); chk("wr_ncr", b, 32'hFF);
    xfer(8'hFF, b); chk("wr_r1", b, 32'h00);
    xfer(8'hFF, b); chk("wr_tok_wait", b, 32'hFF);
    xfer(8'hFE, b);
    for (int i = 0; i < 512; i++) xfer(8'hA5, b);
    xfer(8'h12, b);
    xfer(8'h34, b); chk("wr_crc2_miso", b, 32'hFF);
    xfer(8'hFF, b); chk("wr_dresp", b, 32'h05);
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, b); chk("wr_busy", b, 32'h00);
    end
    xfer(8'hFF, b); chk("wr_done_ff", b, 32'hFF);
    chk("wr_count", wr_n, 512);
    chk("wr_addr_order", wr_bad, 0);
    chk("wr_done_cnt", n_wr_done, 1);
    chk("wr_mem0", mem[0], 32'hA5);
    chk("wr_mem511", mem[511], 32'hA5);
    chk("wr_sector", sector_addr, 32'h00000055);
    chk("wr_rd_start", n_rd_start, 1);

    send_cmd(6'd17, 32'h00000077, 8'hFF);
    xfer(8'hFF, b);
    xfer(8'hFF, b); chk("ab_r1", b, 32'h00);
    xfer(8'hFF, b);
    xfer(8'hFF, b);
    xfer(8'hFF, b); chk("ab_token", b, 32'hFE);
    for (int i = 0; i < 100; i++) xfer(8'hFF, b);
    chk("ab_mid_tx", tx_data, 32'hA5);
    cs_n = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("ab_cs_tx", tx_data, 32'hFF);
    xfer(8'h40, b);
    cs_n = 1'b0;
    @(negedge sys_clk);
    send_cmd(6'd0, 32'h0, 8'h95);
    xfer(8'hFF, b); chk("ab_cmd0_ncr", b, 32'hFF);
    xfer(8'hFF, b); chk("ab_cmd0_r1", b, 32'h01);
    chk("ab_idle", card_idle, 1);
    chk("ab_wr_done", n_wr_done, 1);
    chk("ab_rd_start", n_rd_start, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
